fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the controller.
- Holds the PC and requests instructions from instruction memory over a req/ack handshake.
- Latches each instruction and presents its 5-bit opCode to the controller with a valid/ready handshake.
- On retirement, takes the controller's branch/jump outputs and the ALU zero flag, computes the next PC, and stops on a HALT opcode.

Parameters:
- WIDTH, 32, instruction, PC and retire-counter width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- HALT_OP, 5'b11111, opCode that stops fetching once retired.

Ports:
- clk  input  1  system clock, rising edge.
- nReset  input  1  asynchronous, active-low reset.
- imemReq  output  1  instruction read request.
- imemAddr  output  WIDTH  byte address of the request; always equals pc.
- imemRdata  input  WIDTH  instruction word; valid when imemAck=1.
- imemAck  input  1  memory response strobe.
- instr  output  WIDTH  latched instruction.
- opCode  output  5  instr[31:27], feeds the controller.
- instrValid  output  1  instr/opCode are valid.
- instrReady  input  1  datapath has finished executing; branch/jump/zero are valid this cycle.
- branch  input  1  from controller.
- jump  input  1  from controller.
- zero  input  1  ALU zero flag.
- pc  output  WIDTH  address of the current instruction.
- retireCount  output  WIDTH  number of retired instructions.
- halted  output  1  HALT_OP has been retired.

Behaviour:
- Interface (already decided): one clock, clk; reset nReset is asynchronous and active-low.
- Reset values (while nReset=0): pc=RESET_PC, instr=0, instrValid=0, imemReq=0, retireCount=0, halted=0, state=FETCH.
- An outstanding imemAck during or after reset is discarded.
- States: FETCH, ISSUE, HALTED.
- FETCH:
  - imemReq=1, imemAddr=pc, instrValid=0.
  - When imemAck=1, register instr<=imemRdata and move to ISSUE on the next edge.
  - The request stays asserted with a stable address until acked; no timeout.
- ISSUE:
  - imemReq=0, instrValid=1; instr and opCode are held stable.
  - When instrReady=1 (the handshake), on that edge:
    - pc<=nextPc;
    - retireCount<=retireCount+1;
    - state<=HALTED if opCode==HALT_OP, otherwise FETCH.
  - Without instrReady, stay in ISSUE indefinitely.
- HALTED: imemReq=0, instrValid=0, halted=1, pc frozen. Only reset exits.
- nextPc (combinational, evaluated at the handshake), with pcPlus4 = pc+4:
  - jump=1: {pcPlus4[31:29], instr[26:0], 2'b00} when WIDTH=32; jump has priority over branch.
  - branch&zero=1: pcPlus4 + (signext(instr[15:0]) << 2).
  - otherwise: pcPlus4.
- Arithmetic: all adds are modulo 2^WIDTH (pc and retireCount wrap silently). Every target is word aligned, so pc[1:0] is always 00.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle ack, then ISSUE with instrReady already high). Throughput is at most 1 instruction per 2 cycles.
- imemAck outside FETCH, and branch/jump/zero outside an ISSUE handshake, are ignored.
- Simultaneous events: jump=1 with branch&zero=1 takes the jump target. A HALT instruction still updates pc to nextPc and increments retireCount.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (FETCH, ISSUE, HALTED);
  - HALT_OP;
  - field constants: OPCODE_MSB=31, OPCODE_LSB=27, IMM_MSB=15, JADDR_MSB=26.
- One combinational sub-module, next_pc_logic: inputs pc, instr, branch, jump, zero; output nextPc.

Test Plan:
- Reset, then acks with 0-cycle delay and instrReady held high → imemAddr sequence 0x0, 0x4, 0x8; new instrValid every 2 cycles; retireCount=3 after 3 handshakes.
- Ack delayed 3 cycles and instrReady delayed 2 cycles → imemReq and imemAddr stable while waiting; instr and opCode unchanged during ISSUE; exactly one retire per instruction.
- pc=0x10, instr imm=16'hFFFE, branch=1:
  - zero=1 → next pc=0x0C;
  - zero=0 → next pc=0x14;
  - jump=1 with instr[26:0]=27'h40 → next pc=0x100.
- pc=0xFFFF_FFFC, no branch or jump → pc wraps to 0x0; retireCount preset near 2^32-1 wraps to 0.
- HALT_OP instruction retired → halted=1, imemReq=0 thereafter for 20 cycles; imemAck pulses ignored.
- nReset asserted mid-FETCH with ack arriving the same cycle → pc=RESET_PC, instrValid=0 immediately (asynchronously); the ack is not latched.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and instruction field constants for the fetch
//               stage and its next-PC helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // Fetch stage sequencing states
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Opcode that stops the fetch stage once it retires
  localparam logic [4:0] HALT_OP = 5'b11111;

  // Instruction field boundaries
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 27;
  localparam int IMM_MSB    = 15;
  localparam int JADDR_MSB  = 26;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_logic
// Description : Combinational next-PC selection: sequential, conditional
//               PC-relative branch, or pseudo-direct jump (jump wins).
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_logic #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  output logic [WIDTH-1:0] nextPc
);
  import cpu_pkg::*;

  logic [WIDTH-1:0] w_pc_plus4;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_branch_target;
  logic [WIDTH-1:0] w_jump_target;
  logic             w_unused;

  assign w_pc_plus4      = pc + WIDTH'(4);
  // Sign-extended 16-bit word offset, scaled to bytes below
  assign w_imm_ext       = {{(WIDTH-IMM_MSB-1){instr[IMM_MSB]}}, instr[IMM_MSB:0]};
  assign w_branch_target = w_pc_plus4 + (w_imm_ext << 2);
  // Jump keeps the top bits of the sequential PC and replaces the rest
  assign w_jump_target   = {w_pc_plus4[WIDTH-1:JADDR_MSB+3], instr[JADDR_MSB:0], 2'b00};

  // The opcode bits are consumed by the fetch stage, not by target math
  assign w_unused = &{1'b0, instr[WIDTH-1:JADDR_MSB+1]};

  // Target select: jump has priority over a taken branch
  always_comb begin
    nextPc = w_pc_plus4;
    if (jump) begin
      nextPc = w_jump_target;
    end else if (branch && zero) begin
      nextPc = w_branch_target;
    end
  end

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Requests instructions over a req/ack
//               memory port, issues them to the controller over valid/ready,
//               and updates the PC on retirement until HALT_OP retires.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [4:0]       HALT_OP  = cpu_pkg::HALT_OP
) (
  input  logic             clk,
  input  logic             nReset,
  output logic             imemReq,
  output logic [WIDTH-1:0] imemAddr,
  input  logic [WIDTH-1:0] imemRdata,
  input  logic             imemAck,
  output logic [WIDTH-1:0] instr,
  output logic [4:0]       opCode,
  output logic             instrValid,
  input  logic             instrReady,
  input  logic             branch,
  input  logic             jump,
  input  logic             zero,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] retireCount,
  output logic             halted
);
  import cpu_pkg::*;

  fetch_state_e     r_state;
  fetch_state_e     w_state_next;
  logic             r_armed;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_retire_count;
  logic [WIDTH-1:0] w_next_pc;
  logic             w_accept;
  logic             w_retire;

  // The request is held off for one cycle after reset release so that an ack
  // belonging to a request killed by reset can never be mistaken for a reply.
  assign imemReq     = r_armed && (r_state == FETCH);
  assign imemAddr    = r_pc;
  assign instr       = r_instr;
  assign opCode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign instrValid  = (r_state == ISSUE);
  assign pc          = r_pc;
  assign retireCount = r_retire_count;
  assign halted      = (r_state == HALTED);

  assign w_accept = imemReq && imemAck;
  assign w_retire = (r_state == ISSUE) && instrReady;

  next_pc_logic #(
    .WIDTH (WIDTH)
  ) u_next_pc (
    .pc     (r_pc),
    .instr  (r_instr),
    .branch (branch),
    .jump   (jump),
    .zero   (zero),
    .nextPc (w_next_pc)
  );

  // State register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: FETCH waits for ack, ISSUE waits for ready, HALTED is sticky
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: begin
        if (w_accept) begin
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (instrReady) begin
          w_state_next = (opCode == HALT_OP) ? HALTED : FETCH;
        end
      end
      HALTED: begin
        w_state_next = HALTED;
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  // Request enable: set on the first clock after reset release
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // Instruction latch: captured only on an accepted memory response
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_instr <= '0;
    end else if (w_accept) begin
      r_instr <= imemRdata;
    end
  end

  // PC and retire counter advance together at the issue handshake
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_pc           <= RESET_PC;
      r_retire_count <= '0;
    end else if (w_retire) begin
      r_pc           <= w_next_pc;
      r_retire_count <= r_retire_count + WIDTH'(1);
    end
  end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized scoreboard bench for fetch_unit with a behavioural
//               memory/datapath responder and reference PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [4:0] HALT_C = 5'b11111;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata = '0;
  logic        imemAck = 1'b0;
  logic [31:0] instr;
  logic [4:0]  opCode;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic        branch = 1'b0;
  logic        jump = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic [31:0] retireCount;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .HALT_OP  (HALT_C)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemRdata   (imemRdata),
    .imemAck     (imemAck),
    .instr       (instr),
    .opCode      (opCode),
    .instrValid  (instrValid),
    .instrReady  (instrReady),
    .branch      (branch),
    .jump        (jump),
    .zero        (zero),
    .pc          (pc),
    .retireCount (retireCount),
    .halted      (halted)
  );

  int checks = 0;
  int failures = 0;

  // Scoreboard queues: pushed by stimulus, popped by the monitor
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_rc_q[$];
  logic        exp_h_q[$];

  // Instruction memory contents, filled lazily with random non-HALT words
  logic [31:0] prog [logic [31:0]];

  // Reference model state and stimulus knobs
  logic [31:0] ref_pc;
  logic [31:0] ref_rc;
  logic        ref_halted;
  logic [31:0] cur_word;
  int ack_cnt, rdy_cnt;
  int ack_min, ack_max, rdy_min, rdy_max;
  int ctl_mode;
  bit noise, hold_ready, fast_mode;
  logic [31:0] force_pc;
  logic fb, fj, fz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    logic [31:0] w;
    if (!prog.exists(a)) begin
      w = $urandom;
      if (w[31:27] == HALT_C) w[31:27] = 5'd0;
      prog[a] = w;
    end
    return prog[a];
  endfunction

  // Architectural next-PC rule written with plain arithmetic
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                             input logic b, input logic j, input logic z);
    logic [31:0] pc4;
    int off;
    pc4 = p + 32'd4;
    if (j) return (pc4 & 32'hE000_0000) | ({5'b0, w[26:0]} << 2);
    if (b && z) begin
      off = int'($signed(w[15:0]));
      return pc4 + 32'(off * 4);
    end
    return pc4;
  endfunction

  task automatic init_model();
    ref_pc = 32'h0;
    ref_rc = 32'h0;
    ref_halted = 1'b0;
    cur_word = 32'h0;
    ack_cnt = $urandom_range(ack_max, ack_min);
    rdy_cnt = $urandom_range(rdy_max, rdy_min);
  endtask

  task automatic flush_q();
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_pc_q.delete();
    exp_rc_q.delete();
    exp_h_q.delete();
  endtask

  // One cycle of memory and datapath responder behaviour
  task automatic step();
    logic b, j, z;
    @(posedge clk);
    #1;
    imemAck = 1'b0;
    imemRdata = $urandom;
    if (imemReq) begin
      if (ack_cnt == 0) begin
        imemAck = 1'b1;
        imemRdata = mem_read(imemAddr);
        cur_word = mem_read(ref_pc);
        exp_addr_q.push_back(ref_pc);
        exp_instr_q.push_back(cur_word);
        ack_cnt = $urandom_range(ack_max, ack_min);
      end else begin
        ack_cnt--;
      end
    end else if (noise && $urandom_range(3, 0) == 0) begin
      imemAck = 1'b1;
    end

    instrReady = 1'b0;
    branch = noise && ($urandom_range(1, 0) != 0);
    jump   = noise && ($urandom_range(1, 0) != 0);
    zero   = noise && ($urandom_range(1, 0) != 0);
    if (instrValid) begin
      if (rdy_cnt == 0) begin
        z = $urandom_range(1, 0) != 0;
        b = 1'b0;
        j = 1'b0;
        if (ctl_mode == 1) begin
          b = $urandom_range(1, 0) != 0;
          j = $urandom_range(3, 0) == 0;
        end else if (ctl_mode == 2) begin
          b = (ref_pc == force_pc) ? fb : 1'b0;
          j = (ref_pc == force_pc) ? fj : 1'b0;
          z = (ref_pc == force_pc) ? fz : 1'b0;
        end
        instrReady = 1'b1;
        branch = b;
        jump = j;
        zero = z;
        ref_pc = model_next(ref_pc, cur_word, b, j, z);
        ref_rc = ref_rc + 32'd1;
        if (cur_word[31:27] == HALT_C) ref_halted = 1'b1;
        exp_pc_q.push_back(ref_pc);
        exp_rc_q.push_back(ref_rc);
        exp_h_q.push_back(ref_halted);
        rdy_cnt = $urandom_range(rdy_max, rdy_min);
      end else begin
        rdy_cnt--;
      end
    end else if (hold_ready || (noise && $urandom_range(1, 0) != 0)) begin
      instrReady = 1'b1;
    end
  endtask

  task automatic do_reset();
    nReset = 1'b0;
    imemAck = 1'b0;
    instrReady = 1'b0;
    branch = 1'b0;
    jump = 1'b0;
    zero = 1'b0;
    flush_q();
    prog.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_opcode", {27'b0, opCode}, 32'h0);
    chk("rst_valid", {31'b0, instrValid}, 32'h0);
    chk("rst_req", {31'b0, imemReq}, 32'h0);
    chk("rst_retire", retireCount, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    nReset = 1'b1;
    init_model();
  endtask

  task automatic run_until(input logic [31:0] target);
    int g;
    g = 0;
    while (ref_rc < target && g < 3000) begin
      step();
      g++;
    end
    if (ref_rc < target) begin
      checks++;
      failures++;
      $display("FAIL run_timeout actual=%0d required=%0d", ref_rc, target);
    end
    step();
  endtask

  task automatic set_delays(input int amin, input int amax, input int rmin, input int rmax);
    ack_min = amin;
    ack_max = amax;
    rdy_min = rmin;
    rdy_max = rmax;
  endtask

  // Monitor: pops expectations whenever the DUT shows a transfer
  initial begin : monitor
    int cyc, last_rise;
    bit pend_ret, pend_instr, in_issue, prev_req, prev_ack;
    logic [31:0] exp_w, held, prev_addr;
    cyc = 0;
    last_rise = -1;
    pend_ret = 0;
    pend_instr = 0;
    in_issue = 0;
    prev_req = 0;
    prev_ack = 0;
    prev_addr = '0;
    exp_w = '0;
    held = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!nReset) begin
        pend_ret = 0;
        pend_instr = 0;
        in_issue = 0;
        prev_req = 0;
        prev_ack = 0;
        last_rise = -1;
        continue;
      end
      if (pend_ret) begin
        if (exp_pc_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL retire_unexpected actual=handshake required=none");
        end else begin
          chk("retire_pc", pc, exp_pc_q.pop_front());
          chk("retire_count", retireCount, exp_rc_q.pop_front());
          chk("retire_halted", {31'b0, halted}, {31'b0, exp_h_q.pop_front()});
        end
        pend_ret = 0;
      end
      if (pend_instr) begin
        chk("instr_latch", instr, exp_w);
        chk("opcode", {27'b0, opCode}, {27'b0, exp_w[31:27]});
        chk("valid_after_ack", {31'b0, instrValid}, 32'h1);
        pend_instr = 0;
      end
      if (instrValid) begin
        if (!in_issue) begin
          held = instr;
          in_issue = 1;
          if (fast_mode && last_rise >= 0) chk("valid_spacing", 32'(cyc - last_rise), 32'd2);
          last_rise = cyc;
        end else begin
          chk("instr_stable", instr, held);
          chk("opcode_stable", {27'b0, opCode}, {27'b0, held[31:27]});
        end
      end else begin
        in_issue = 0;
      end
      if (prev_req && !prev_ack) begin
        chk("req_hold", {31'b0, imemReq}, 32'h1);
        chk("addr_hold", imemAddr, prev_addr);
      end
      if (imemReq && imemAck) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL fetch_unexpected actual=%h required=none", imemAddr);
        end else begin
          chk("fetch_addr", imemAddr, exp_addr_q.pop_front());
          exp_w = exp_instr_q.pop_front();
          pend_instr = 1;
        end
      end
      if (instrValid && instrReady) pend_ret = 1;
      prev_req = imemReq;
      prev_ack = imemAck;
      prev_addr = imemAddr;
    end
  end

  // Stimulus sequence
  initial begin : stimulus
    logic [31:0] targets [3];
    targets[0] = 32'h0000_000C;
    targets[1] = 32'h0000_0014;
    targets[2] = 32'h0000_0100;
    ctl_mode = 0;
    noise = 0;
    hold_ready = 0;
    fast_mode = 0;
    force_pc = '0;
    fb = 0;
    fj = 0;
    fz = 0;

    // Back-to-back: immediate ack, ready held high
    set_delays(0, 0, 0, 0);
    hold_ready = 1;
    fast_mode = 1;
    do_reset();
    run_until(32'd3);
    chk("fast_retire3", retireCount, 32'd3);
    hold_ready = 0;
    fast_mode = 0;

    // Fixed wait states on both handshakes
    set_delays(3, 3, 2, 2);
    do_reset();
    run_until(32'd4);
    chk("slow_retire4", retireCount, 32'd4);

    // Random traffic with random control and ignored noise
    set_delays(0, 3, 0, 3);
    ctl_mode = 1;
    noise = 1;
    do_reset();
    run_until(32'd150);
    noise = 0;

    // Branch taken, branch not taken, jump over taken branch at pc 0x10
    for (int k = 0; k < 3; k++) begin
      set_delays(0, 1, 0, 1);
      ctl_mode = 2;
      do_reset();
      force_pc = 32'h10;
      prog[32'h10] = (k < 2) ? {5'd4, 11'd0, 16'hFFFE} : {5'd4, 27'h40};
      fb = 1'b1;
      fj = (k == 2);
      fz = (k != 1);
      run_until(32'd5);
      chk("branch_target", pc, targets[k]);
    end

    // Negative branch from 0 lands at the top of memory, then wraps to 0
    do_reset();
    force_pc = 32'h0;
    prog[32'h0] = {5'd4, 11'd0, 16'hFFFE};
    fb = 1'b1;
    fj = 1'b0;
    fz = 1'b1;
    run_until(32'd1);
    chk("wrap_top", pc, 32'hFFFF_FFFC);
    run_until(32'd2);
    chk("wrap_zero", pc, 32'h0);

    // HALT retires, still moves pc, then nothing more is fetched
    ctl_mode = 0;
    set_delays(0, 2, 0, 2);
    do_reset();
    prog[32'h4] = {HALT_C, 27'($urandom)};
    run_until(32'd2);
    chk("halt_flag", {31'b0, halted}, 32'h1);
    noise = 1;
    repeat (20) begin
      step();
      chk("halt_req", {31'b0, imemReq}, 32'h0);
      chk("halt_valid", {31'b0, instrValid}, 32'h0);
      chk("halt_pc", pc, 32'h8);
      chk("halt_retire", retireCount, 32'd2);
    end
    noise = 0;

    // Reset asserted in a FETCH cycle whose ack is on the bus
    set_delays(0, 0, 0, 0);
    do_reset();
    prog[32'h4] = 32'h2000_0123;
    run_until(32'd2);
    for (int g = 0; g < 10 && !imemAck; g++) step();
    chk("pre_reset_ack", {31'b0, imemAck}, 32'h1);
    #1;
    nReset = 1'b0;
    #1;
    flush_q();
    chk("async_pc", pc, 32'h0);
    chk("async_valid", {31'b0, instrValid}, 32'h0);
    chk("async_req", {31'b0, imemReq}, 32'h0);
    chk("async_retire", retireCount, 32'h0);
    @(posedge clk);
    #1;
    chk("reset_ack_instr", instr, 32'h0);
    chk("reset_ack_valid", {31'b0, instrValid}, 32'h0);
    imemAck = 1'b0;
    nReset = 1'b1;
    init_model();
    step();
    chk("post_reset_instr", instr, 32'h0);
    chk("post_reset_valid", {31'b0, instrValid}, 32'h0);
    run_until(32'd2);
    chk("post_reset_retire", retireCount, 32'd2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fetch_unit
`default_nettype wire
